jtag_tap_controller: RTL
========================

Name: jtag_tap_controller

Overview:
- IEEE 1149.1-style TAP controller that sequences the 14-cell boundary-scan register (BSR) from TMS/TDI.
- Contains the 16-state TAP FSM, a 3-bit instruction register and a 1-bit bypass register.
- Generates shiftDR, clockDR, updateDR and mode for the BSR, and drives TDO.
- Sits between the chip JTAG pins and the BSR chain.

Parameters:
- IR_WIDTH, 3: instruction register width.
- IR_CAPTURE, 3'b001: value loaded into the IR shift stage in Capture-IR.
- EXTEST, 3'b000: opcode; BSR selected, mode=1.
- SAMPLE_PRELOAD, 3'b001: opcode; BSR selected, mode=0.
- INTEST, 3'b010: opcode; BSR selected, mode=1.
- BYPASS, 3'b111: opcode; bypass selected, mode=0. All undefined opcodes decode as BYPASS.

Ports:
- TCK  input  1  Test clock; the only clock. Both edges are used.
- TRST  input  1  Asynchronous, active-low reset.
- TMS  input  1  Mode select, sampled on posedge TCK.
- TDI  input  1  Serial data in; routed to the BSR scan_in, IR and bypass.
- bsr_scan_out  input  1  Serial output of the BSR.
- TDO  output  1  Serial data out, registered on negedge TCK.
- TDO_en  output  1  High while in Shift-DR or Shift-IR, registered on negedge TCK.
- shiftDR  output  1  To BSR: 1 selects shift, 0 selects capture.
- clockDR  output  1  To BSR: gated TCK.
- updateDR  output  1  To BSR: update strobe.
- mode  output  1  To BSR: 1 selects the output register onto the pins.
- tap_state  output  4  Current FSM state code.
- instruction  output  IR_WIDTH  Currently active (updated) instruction.

Behaviour:
- State codes: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
- Transitions occur on posedge TCK, given as next state for TMS=0 / TMS=1:
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PauseDR / UpdDR
  - PauseDR: PauseDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - SelIR: CapIR / TLR
  - IR-side states mirror the DR side.
- Five consecutive TMS=1 clocks reach TLR from any state.
- Reset (TRST low, asynchronous, any phase including mid-shift):
  - state=TLR, instruction=BYPASS, IR shift stage=IR_CAPTURE, bypass=0.
  - shiftDR=0, updateDR=0, clockDR enable=0, TDO=0, TDO_en=0.
- Entering TLR via TMS: instruction is forced to BYPASS on the negedge TCK in TLR.
- Decode: bsr_sel is 1 for EXTEST, SAMPLE_PRELOAD and INTEST. mode is 1 for EXTEST and INTEST, combinational from instruction.
- Negedge-TCK registers (all reset to 0):
  - shiftDR_r = (state==ShDR).
  - clk_en = bsr_sel & (state==CapDR or ShDR).
  - updateDR = bsr_sel & (state==UpdDR).
  - updIR = (state==UpdIR).
- clockDR = TCK & clk_en. Because clk_en only changes while TCK is low, clockDR is glitch-free and its rising edges coincide with posedge TCK in CapDR/ShDR. First edge: capture (shiftDR=0). Subsequent edges: shift.
- updateDR rises at the negedge in UpdDR and falls at the next negedge.
- IR shift stage (posedge TCK):
  - CapIR loads IR_CAPTURE.
  - ShIR shifts TDI into the MSB; the LSB goes out first.
  - On the negedge in UpdIR, instruction <= shift stage.
- Bypass register (posedge TCK): 0 in CapDR; TDI in ShDR, only when bsr_sel=0.
- TDO (negedge TCK):
  - ShIR: IR shift LSB.
  - ShDR: bsr_scan_out if bsr_sel, else bypass.
  - Otherwise TDO holds its value and TDO_en=0.
- Pause states: no clockDR edges; the BSR contents are held.

Test Plan:
- Assert TRST=0 mid-ShDR -> state=F, instruction=3'b111, clockDR/updateDR/shiftDR/TDO_en=0 immediately without a TCK edge; after release with TMS=0 for 1 clock, state=C.
- From RTI, TMS=1 for 5 clocks -> state=F. Walk every state/TMS arc and check tap_state codes against the transition list.
- Load IR=000 (EXTEST) via ShIR with TDI=0,0,0 -> TDO shifts out 1,0,0 (capture 001); after UpdIR, instruction=000 and mode=1.
- SAMPLE_PRELOAD, then CapDR plus 14 ShDR clocks with TDI=1 -> exactly 15 clockDR rising edges, first with shiftDR=0; one updateDR pulse in UpdDR; mode=0.
- BYPASS, 8 ShDR clocks with TDI pattern 10110011 -> TDO emits 0 then the pattern delayed by 1; no clockDR or updateDR pulses.
- EXTEST, enter PauseDR for 4 clocks mid-shift, then Ex2DR->ShDR -> no clockDR edges during the pause; the scan resumes with data intact.

Source files
------------

// File: rtl/jtag_tap_controller.sv
// ----------------------------------------------------------------------------
// jtag_tap_controller
// IEEE 1149.1-style TAP controller driving a boundary-scan register (BSR).
// Holds the 16-state TAP FSM, the instruction register (shift stage plus
// active instruction) and the 1-bit bypass register. Produces the BSR control
// strobes (shiftDR, clockDR, updateDR, mode) and the registered TDO.
//
// Ports:
//   TCK          test clock, both edges used
//   TRST         asynchronous active-low reset
//   TMS          mode select, sampled on posedge TCK
//   TDI          serial data in (IR, bypass and BSR scan_in)
//   bsr_scan_out serial output of the BSR
//   TDO          serial data out, registered on negedge TCK
//   TDO_en       high while in Shift-DR / Shift-IR, registered on negedge TCK
//   shiftDR      to BSR: 1 = shift, 0 = capture
//   clockDR      to BSR: gated TCK
//   updateDR     to BSR: update strobe
//   mode         to BSR: 1 drives the output register onto the pins
//   tap_state    current FSM state code
//   instruction  active (updated) instruction
// ----------------------------------------------------------------------------
module jtag_tap_controller #(
  parameter int                  IR_WIDTH       = 3,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE     = 3'b001,
  parameter logic [IR_WIDTH-1:0] EXTEST         = 3'b000,
  parameter logic [IR_WIDTH-1:0] SAMPLE_PRELOAD = 3'b001,
  parameter logic [IR_WIDTH-1:0] INTEST         = 3'b010,
  parameter logic [IR_WIDTH-1:0] BYPASS         = 3'b111
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                bsr_scan_out,
  output logic                TDO,
  output logic                TDO_en,
  output logic                shiftDR,
  output logic                clockDR,
  output logic                updateDR,
  output logic                mode,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] instruction
);

  typedef enum logic [3:0] {
    TLR      = 4'hF, RTI      = 4'hC,
    SEL_DR   = 4'h7, CAP_DR   = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
    PAUSE_DR = 4'h3, EX2_DR   = 4'h0, UPD_DR = 4'h5,
    SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
    PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR = 4'hD
  } tap_state_t;

  tap_state_t          state_r;
  tap_state_t          state_next_s;
  logic [IR_WIDTH-1:0] ir_shift_r;
  logic [IR_WIDTH-1:0] instruction_r;
  logic                bypass_r;
  logic                shift_dr_r;
  logic                clk_en_r;
  logic                update_dr_r;
  logic                tdo_r;
  logic                tdo_en_r;
  logic                bsr_sel_s;
  logic                mode_s;

  // TAP next-state function, indexed by current state and TMS
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      TLR:      state_next_s = TMS ? TLR      : RTI;
      RTI:      state_next_s = TMS ? SEL_DR   : RTI;
      SEL_DR:   state_next_s = TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   state_next_s = TMS ? EX1_DR   : SH_DR;
      SH_DR:    state_next_s = TMS ? EX1_DR   : SH_DR;
      EX1_DR:   state_next_s = TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_next_s = TMS ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_next_s = TMS ? UPD_DR   : SH_DR;
      UPD_DR:   state_next_s = TMS ? SEL_DR   : RTI;
      SEL_IR:   state_next_s = TMS ? TLR      : CAP_IR;
      CAP_IR:   state_next_s = TMS ? EX1_IR   : SH_IR;
      SH_IR:    state_next_s = TMS ? EX1_IR   : SH_IR;
      EX1_IR:   state_next_s = TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_next_s = TMS ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_next_s = TMS ? UPD_IR   : SH_IR;
      UPD_IR:   state_next_s = TMS ? SEL_DR   : RTI;
      default:  state_next_s = TLR;
    endcase
  end

  // Instruction decode; any opcode not listed behaves as BYPASS
  always_comb begin
    bsr_sel_s = 1'b0;
    mode_s    = 1'b0;
    case (instruction_r)
      EXTEST:         begin bsr_sel_s = 1'b1; mode_s = 1'b1; end
      SAMPLE_PRELOAD: begin bsr_sel_s = 1'b1; mode_s = 1'b0; end
      INTEST:         begin bsr_sel_s = 1'b1; mode_s = 1'b1; end
      default:        begin bsr_sel_s = 1'b0; mode_s = 1'b0; end
    endcase
  end

  // TAP state register
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_r <= TLR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // IR shift stage: capture fixed pattern, then shift TDI in at the MSB
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_shift_r <= IR_CAPTURE;
    end else if (state_r == CAP_IR) begin
      ir_shift_r <= IR_CAPTURE;
    end else if (state_r == SH_IR) begin
      ir_shift_r <= {TDI, ir_shift_r[IR_WIDTH-1:1]};
    end
  end

  // Bypass bit: cleared on capture, follows TDI only when the BSR is not selected
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      bypass_r <= 1'b0;
    end else if (state_r == CAP_DR) begin
      bypass_r <= 1'b0;
    end else if ((state_r == SH_DR) && !bsr_sel_s) begin
      bypass_r <= TDI;
    end
  end

  // Falling-edge outputs: changing only while TCK is low keeps clockDR glitch-free
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      instruction_r <= BYPASS;
      shift_dr_r    <= 1'b0;
      clk_en_r      <= 1'b0;
      update_dr_r   <= 1'b0;
      tdo_r         <= 1'b0;
      tdo_en_r      <= 1'b0;
    end else begin
      if (state_r == UPD_IR) begin
        instruction_r <= ir_shift_r;
      end else if (state_r == TLR) begin
        instruction_r <= BYPASS;
      end
      shift_dr_r  <= (state_r == SH_DR);
      clk_en_r    <= bsr_sel_s && ((state_r == CAP_DR) || (state_r == SH_DR));
      update_dr_r <= bsr_sel_s && (state_r == UPD_DR);
      tdo_en_r    <= (state_r == SH_DR) || (state_r == SH_IR);
      // TDO holds its last value outside the shift states
      if (state_r == SH_IR) begin
        tdo_r <= ir_shift_r[0];
      end else if (state_r == SH_DR) begin
        tdo_r <= bsr_sel_s ? bsr_scan_out : bypass_r;
      end
    end
  end

  assign clockDR     = TCK & clk_en_r;
  assign shiftDR     = shift_dr_r;
  assign updateDR    = update_dr_r;
  assign TDO         = tdo_r;
  assign TDO_en      = tdo_en_r;
  assign mode        = mode_s;
  assign tap_state   = state_r;
  assign instruction = instruction_r;

endmodule
